// File: rtl/psram_pkg.sv
// rtl/psram_pkg.sv - state encoding and phase lengths for the PSRAM DDR sequencer
package psram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CS_SETUP = 3'd1,
        ST_CA       = 3'd2,
        ST_LAT      = 3'd3,
        ST_WDATA    = 3'd4,
        ST_RDATA    = 3'd5,
        ST_CS_HOLD  = 3'd6
    } state_t;

    localparam int CA_BEATS     = 3;
    localparam int CS_SETUP_CYC = 1;
    localparam int CS_HOLD_CYC  = 1;

endpackage

// File: rtl/psram_ca_mux.sv
// rtl/psram_ca_mux.sv - CA beat index to {d0,d1} byte pair
// Ports:
//   cmd_byte  in  8   command byte (write or read opcode)
//   addr      in  32  latched byte address
//   beat_idx  in  2   CA beat 0..2
//   d0, d1    out 8   rising/falling-edge bytes for this beat
module psram_ca_mux
    import psram_pkg::*;
(
    input  logic [7:0]  cmd_byte,
    input  logic [31:0] addr,
    input  logic [1:0]  beat_idx,
    output logic [7:0]  d0,
    output logic [7:0]  d1
);

    // CA byte stream: cmd, addr MSB first, then a zero pad byte.
    always_comb begin
        d0 = 8'h00;
        d1 = 8'h00;
        case (beat_idx)
            2'd0: begin d0 = cmd_byte;     d1 = addr[31:24]; end
            2'd1: begin d0 = addr[23:16];  d1 = addr[15:8];  end
            2'd2: begin d0 = addr[7:0];    d1 = 8'h00;       end
            default: begin d0 = 8'h00;     d1 = 8'h00;       end
        endcase
    end

endmodule

// File: rtl/psram_ddr_seq.sv
// rtl/psram_ddr_seq.sv - PSRAM DDR transaction sequencer feeding DQ/CE#/CK ODDRs
// Optional DM datapath: define PSRAM_DM_EN (adds dm_d0, dm_d1, wr_mask).
// Ports:
//   sys_clk, sys_rst                 clock, async active-high reset
//   cmd_valid/cmd_ready/cmd_wr/cmd_addr/cmd_len   command handshake
//   wr_valid/wr_ready/wr_data        write beat stream
//   oddr_d0/oddr_d1/oddr_oe          DQ ODDR data and output enable
//   ce_n, ck_en, rd_win              chip select, CK gate, read window
//   busy, done                       status
module psram_ddr_seq
    import psram_pkg::*;
#(
    parameter int         DQ_W    = 8,
    parameter int         LEN_W   = 7,
    parameter int         LAT_CYC = 6,
    parameter logic [7:0] WR_CMD  = 8'hA0,
    parameter logic [7:0] RD_CMD  = 8'h20
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [31:0]       cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [2*DQ_W-1:0] wr_data,
    output logic [DQ_W-1:0]   oddr_d0,
    output logic [DQ_W-1:0]   oddr_d1,
    output logic              oddr_oe,
    output logic              ce_n,
    output logic              ck_en,
    output logic              rd_win,
    output logic              busy,
    output logic              done
`ifdef PSRAM_DM_EN
    ,
    output logic              dm_d0,
    output logic              dm_d1,
    input  logic [1:0]        wr_mask
`endif
);

    state_t             state_q, state_d;
    logic [3:0]         phase_q, phase_d;
    logic [LEN_W-1:0]   beat_q, beat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [31:0]        addr_q, addr_d;
    logic               wr_q, wr_d;
    logic               ce_n_q, ce_n_d;
    logic               oe_q, oe_d;
    logic               ck_en_q, ck_en_d;
    logic               rd_win_q, rd_win_d;
    logic               done_q, done_d;
    logic [DQ_W-1:0]    d0_q, d0_d;
    logic [DQ_W-1:0]    d1_q, d1_d;
    logic [7:0]         ca_d0, ca_d1;
    logic               wr_fire;

    assign wr_fire = (state_q == ST_WDATA) && wr_valid;

    psram_ca_mux u_ca_mux (
        .cmd_byte (wr_q ? WR_CMD : RD_CMD),
        .addr     (addr_q),
        .beat_idx (phase_d[1:0]),
        .d0       (ca_d0),
        .d1       (ca_d1)
    );

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        beat_d  = beat_q;
        len_d   = len_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = ST_CS_SETUP;
                    phase_d = 4'd0;
                    wr_d    = cmd_wr;
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                end
            end
            ST_CS_SETUP: begin
                if (phase_q == 4'(CS_SETUP_CYC - 1)) begin
                    state_d = ST_CA;
                    phase_d = 4'd0;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            ST_CA: begin
                if (phase_q == 4'(CA_BEATS - 1)) begin
                    state_d = ST_LAT;
                    phase_d = 4'd0;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            ST_LAT: begin
                if (phase_q == 4'(LAT_CYC - 1)) begin
                    phase_d = 4'd0;
                    beat_d  = '0;
                    if (len_q == '0)
                        state_d = ST_CS_HOLD;
                    else
                        state_d = wr_q ? ST_WDATA : ST_RDATA;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            ST_WDATA: begin
                // Beat count only advances on a consumed beat; stalls hold it.
                if (wr_valid) begin
                    beat_d = beat_q + LEN_W'(1);
                    if (beat_q + LEN_W'(1) == len_q)
                        state_d = ST_CS_HOLD;
                end
            end
            ST_RDATA: begin
                beat_d = beat_q + LEN_W'(1);
                if (beat_q + LEN_W'(1) == len_q)
                    state_d = ST_CS_HOLD;
            end
            ST_CS_HOLD: begin
                if (phase_q == 4'(CS_HOLD_CYC - 1)) begin
                    state_d = ST_IDLE;
                    phase_d = 4'd0;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = 4'd0;
            end
        endcase

        // Pin values are registered against the state being entered, so they
        // line up with state_q in the following cycle.
        ce_n_d   = (state_d == ST_IDLE);
        oe_d     = (state_d == ST_CA) || (state_d == ST_WDATA);
        ck_en_d  = (state_d == ST_CA) || (state_d == ST_LAT) || (state_d == ST_RDATA);
        rd_win_d = (state_d == ST_RDATA);
        done_d   = (state_q == ST_CS_HOLD) && (state_d == ST_IDLE);

        d0_d = '0;
        d1_d = '0;
        case (state_d)
            ST_CA: begin
                d0_d = DQ_W'(ca_d0);
                d1_d = DQ_W'(ca_d1);
            end
            ST_WDATA: begin
                d0_d = wr_fire ? wr_data[DQ_W-1:0]      : d0_q;
                d1_d = wr_fire ? wr_data[2*DQ_W-1:DQ_W] : d1_q;
            end
            default: begin
                d0_d = '0;
                d1_d = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            beat_q   <= '0;
            len_q    <= '0;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            ce_n_q   <= 1'b1;
            oe_q     <= 1'b0;
            ck_en_q  <= 1'b0;
            rd_win_q <= 1'b0;
            done_q   <= 1'b0;
            d0_q     <= '0;
            d1_q     <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            beat_q   <= beat_d;
            len_q    <= len_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            ce_n_q   <= ce_n_d;
            oe_q     <= oe_d;
            ck_en_q  <= ck_en_d;
            rd_win_q <= rd_win_d;
            done_q   <= done_d;
            d0_q     <= d0_d;
            d1_q     <= d1_d;
        end
    end

    // Write beats pass straight through to the ODDR inputs in the cycle they
    // are consumed (the ODDR is the output register). A stalled cycle shows
    // the held last beat and pauses CK.
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign wr_ready  = wr_fire;
    assign oddr_d0   = wr_fire ? wr_data[DQ_W-1:0]      : d0_q;
    assign oddr_d1   = wr_fire ? wr_data[2*DQ_W-1:DQ_W] : d1_q;
    assign oddr_oe   = oe_q;
    assign ce_n      = ce_n_q;
    assign ck_en     = ck_en_q | wr_fire;
    assign rd_win    = rd_win_q;
    assign done      = done_q;

`ifdef PSRAM_DM_EN
    logic [1:0] dm_q, dm_d;

    always_comb begin
        dm_d = 2'b00;
        if (state_d == ST_WDATA)
            dm_d = wr_fire ? wr_mask : dm_q;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            dm_q <= 2'b00;
        else
            dm_q <= dm_d;
    end

    assign dm_d0 = wr_fire ? wr_mask[0] : dm_q[0];
    assign dm_d1 = wr_fire ? wr_mask[1] : dm_q[1];
`endif

endmodule

// File: tb/tb_psram_ddr_seq.sv
// tb/tb_psram_ddr_seq.sv - scoreboard bench for psram_ddr_seq
module tb_psram_ddr_seq;

    localparam int DQ_W  = 8;
    localparam int LEN_W = 7;
    localparam int LAT   = 6;

    // flag order: {ce_n, oe, ck_en, rd_win, done, wr_ready}
    localparam logic [5:0] F_SETUP  = 6'b000000;
    localparam logic [5:0] F_CA     = 6'b011000;
    localparam logic [5:0] F_LAT    = 6'b001000;
    localparam logic [5:0] F_WBEAT  = 6'b011001;
    localparam logic [5:0] F_WSTALL = 6'b010000;
    localparam logic [5:0] F_RBEAT  = 6'b001100;
    localparam logic [5:0] F_HOLD   = 6'b000000;
    localparam logic [5:0] F_DONE   = 6'b100010;

    logic              sys_clk;
    logic              sys_rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic [31:0]       cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [2*DQ_W-1:0] wr_data;
    logic [DQ_W-1:0]   oddr_d0;
    logic [DQ_W-1:0]   oddr_d1;
    logic              oddr_oe;
    logic              ce_n;
    logic              ck_en;
    logic              rd_win;
    logic              busy;
    logic              done;

    psram_ddr_seq #(
        .DQ_W    (DQ_W),
        .LEN_W   (LEN_W),
        .LAT_CYC (LAT),
        .WR_CMD  (8'hA0),
        .RD_CMD  (8'h20)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .oddr_d0   (oddr_d0),
        .oddr_d1   (oddr_d1),
        .oddr_oe   (oddr_oe),
        .ce_n      (ce_n),
        .ck_en     (ck_en),
        .rd_win    (rd_win),
        .busy      (busy),
        .done      (done)
    );

    typedef struct packed {
        logic       ce_n;
        logic       oe;
        logic       ck_en;
        logic       rd_win;
        logic       done;
        logic       wr_ready;
        logic [7:0] d0;
        logic [7:0] d1;
    } pins_t;

    typedef struct {
        logic [15:0] data;
        int          stall;
    } wbeat_t;

    pins_t  exp_q[$];
    wbeat_t wbeats[$];
    int     checks    = 0;
    int     errors    = 0;
    int     cyc       = 0;
    int     rd_cnt    = 0;
    int     wr_cnt    = 0;
    int     last_done = -1;

    function automatic pins_t mk(input logic [5:0] f, input logic [7:0] d0, input logic [7:0] d1);
        pins_t p;
        p.ce_n     = f[5];
        p.oe       = f[4];
        p.ck_en    = f[3];
        p.rd_win   = f[2];
        p.done     = f[1];
        p.wr_ready = f[0];
        p.d0       = d0;
        p.d1       = d1;
        return p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s got timeout want event", name);
    endtask

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        forever begin
            @(posedge sys_clk);
            cyc++;
        end
    end

    // Monitor: every cycle with CE# low or done high must match the next
    // expected pin record.
    initial begin
        pins_t act;
        pins_t e;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst) begin
                if (rd_win)   rd_cnt++;
                if (wr_ready) wr_cnt++;
                if (done)     last_done = cyc;
                if (!ce_n || done) begin
                    act = mk({ce_n, oddr_oe, ck_en, rd_win, done, wr_ready}, oddr_d0, oddr_d1);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_cycle cyc=%0d got %h want none", cyc, act);
                    end else begin
                        e = exp_q.pop_front();
                        if (act !== e) begin
                            errors++;
                            $display("FAIL pins cyc=%0d got ce_n=%b oe=%b ck=%b rd=%b done=%b wrr=%b d0=%h d1=%h want ce_n=%b oe=%b ck=%b rd=%b done=%b wrr=%b d0=%h d1=%h",
                                     cyc, act.ce_n, act.oe, act.ck_en, act.rd_win, act.done, act.wr_ready, act.d0, act.d1,
                                     e.ce_n, e.oe, e.ck_en, e.rd_win, e.done, e.wr_ready, e.d0, e.d1);
                        end
                    end
                end
            end
        end
    end

    // Write source: presents queued beats, pausing for a beat's stall count
    // after it is consumed.
    initial begin
        bit fired;
        int stall_left;
        stall_left = 0;
        wr_valid   = 1'b0;
        wr_data    = '0;
        forever begin
            @(negedge sys_clk);
            fired = wr_valid && wr_ready;
            @(posedge sys_clk);
            #1;
            if (fired && wbeats.size() > 0) begin
                stall_left = wbeats[0].stall;
                void'(wbeats.pop_front());
            end
            if (stall_left > 0) begin
                wr_valid = 1'b0;
                stall_left--;
            end else if (wbeats.size() > 0) begin
                wr_valid = 1'b1;
                wr_data  = wbeats[0].data;
            end else begin
                wr_valid = 1'b0;
            end
        end
    end

    task automatic issue(input logic wr, input logic [31:0] addr, input int len,
                         input int stall_after, input int stall_cyc, input bit hold,
                         output int t_acc);
        logic [7:0]  b [6];
        logic [15:0] dat;
        b[0] = wr ? 8'hA0 : 8'h20;
        b[1] = addr[31:24];
        b[2] = addr[23:16];
        b[3] = addr[15:8];
        b[4] = addr[7:0];
        b[5] = 8'h00;
        exp_q.push_back(mk(F_SETUP, 8'h00, 8'h00));
        for (int k = 0; k < 3; k++)
            exp_q.push_back(mk(F_CA, b[2*k], b[2*k+1]));
        for (int k = 0; k < LAT; k++)
            exp_q.push_back(mk(F_LAT, 8'h00, 8'h00));
        if (wr) begin
            for (int i = 0; i < len; i++) begin
                dat = 16'h2211 + 16'(i) * 16'h1111;
                wbeats.push_back('{dat, (i + 1 == stall_after) ? stall_cyc : 0});
                exp_q.push_back(mk(F_WBEAT, dat[7:0], dat[15:8]));
                if (i + 1 == stall_after && i + 1 < len)
                    for (int s = 0; s < stall_cyc; s++)
                        exp_q.push_back(mk(F_WSTALL, dat[7:0], dat[15:8]));
            end
        end else begin
            for (int i = 0; i < len; i++)
                exp_q.push_back(mk(F_RBEAT, 8'h00, 8'h00));
        end
        exp_q.push_back(mk(F_HOLD, 8'h00, 8'h00));
        exp_q.push_back(mk(F_DONE, 8'h00, 8'h00));

        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_len   = LEN_W'(len);
        cmd_valid = 1'b1;
        t_acc     = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge sys_clk);
            #1;
            if (cmd_ready) begin
                t_acc = cyc;
                break;
            end
        end
        if (t_acc < 0) fail_timeout("cmd_accept");
        @(posedge sys_clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge sys_clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            fail_timeout(name);
            exp_q.delete();
        end
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t2, w0, r0;
        sys_rst   = 1'b1;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_ce_n",   32'(ce_n),    32'd1);
        chk("rst_oe",     32'(oddr_oe), 32'd0);
        chk("rst_ck_en",  32'(ck_en),   32'd0);
        chk("rst_rd_win", 32'(rd_win),  32'd0);
        chk("rst_done",   32'(done),    32'd0);
        chk("rst_d0d1",   32'({oddr_d0, oddr_d1}), 32'd0);
        chk("rst_busy",   32'(busy),    32'd0);
        sys_rst = 1'b0;
        @(posedge sys_clk);
        #1;
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // 1: write len 4, no stalls
        w0 = wr_cnt;
        issue(1'b1, 32'h0012_3456, 4, 0, 0, 1'b0, t);
        wait_idle("t1_idle");
        chk("t1_done_lat", 32'(last_done - t), 32'd16);
        chk("t1_wr_pulses", 32'(wr_cnt - w0), 32'd4);

        // 2: read len 8
        r0 = rd_cnt;
        issue(1'b0, 32'h0012_3456, 8, 0, 0, 1'b0, t);
        wait_idle("t2_idle");
        chk("t2_rd_win_cycles", 32'(rd_cnt - r0), 32'd8);
        chk("t2_done_lat", 32'(last_done - t), 32'd20);

        // 3: write len 4, wr_valid low 2 cycles after beat 1
        w0 = wr_cnt;
        issue(1'b1, 32'hCAFE_0010, 4, 1, 2, 1'b0, t);
        wait_idle("t3_idle");
        chk("t3_wr_pulses", 32'(wr_cnt - w0), 32'd4);
        chk("t3_done_lat", 32'(last_done - t), 32'd18);

        // 4: len 0 write, a beat is offered but never taken
        w0 = wr_cnt;
        wbeats.push_back('{16'hDEAD, 0});
        issue(1'b1, 32'h0000_0040, 0, 0, 0, 1'b0, t);
        wait_idle("t4_idle");
        chk("t4_wr_pulses", 32'(wr_cnt - w0), 32'd0);
        chk("t4_done_lat", 32'(last_done - t), 32'd12);
        wbeats.delete();
        repeat (2) @(posedge sys_clk);
        #1;

        // 5: reset during write beat 2
        w0 = wr_cnt;
        issue(1'b1, 32'h0000_1000, 4, 0, 0, 1'b0, t);
        for (int n = 0; n < 100 && (wr_cnt - w0) < 2; n++) begin
            @(negedge sys_clk);
            #1;
        end
        chk("t5_reached_beat2", 32'(wr_cnt - w0), 32'd2);
        #1;
        sys_rst = 1'b1;
        #1;
        chk("t5_rst_ce_n",  32'(ce_n),    32'd1);
        chk("t5_rst_oe",    32'(oddr_oe), 32'd0);
        chk("t5_rst_ck_en", 32'(ck_en),   32'd0);
        chk("t5_rst_busy",  32'(busy),    32'd0);
        exp_q.delete();
        wbeats.delete();
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        chk("t5_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge sys_clk);
        #1;
        issue(1'b0, 32'h0000_2000, 2, 0, 0, 1'b0, t);
        wait_idle("t5_idle");
        chk("t5_next_done_lat", 32'(last_done - t), 32'd14);

        // 6: back-to-back with cmd_valid held
        issue(1'b1, 32'h0000_3000, 2, 0, 0, 1'b1, t);
        issue(1'b0, 32'h0000_3004, 3, 0, 0, 1'b0, t2);
        chk("t6_accept_in_done", 32'(t2), 32'(last_done));
        chk("t6_accept_gap", 32'(t2 - t), 32'd14);
        wait_idle("t6_idle");
        chk("t6_second_done_lat", 32'(last_done - t2), 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
